// File: rtl/nv_fifo_ctrl_rwsp_64x16.sv
// ---------------------------------------------------------------------------
// nv_fifo_ctrl_rwsp_64x16
//   Valid/ready FIFO controller for an external 64x16 1R1W RAM. The RAM has a
//   registered read address (loaded on ram_re) and an output data register
//   (loaded on ram_ore). This block maps a two-stage read pipe onto those two
//   RAM registers. The result is a pop stream that can sustain one push and
//   one pop every cycle without any local skid storage.
//
// Ports
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   wr_pvld / wr_prdy / wr_pd        : push stream
//   rd_pvld / rd_prdy / rd_pd        : pop stream (rd_pd is ram_dout)
//   ram_we / ram_wa / ram_di         : RAM write port
//   ram_re / ram_ra                  : RAM read-address port
//   ram_ore                          : RAM output-register enable
//   ram_dout                         : RAM registered read data
//   fifo_count                       : entries held, 0..DEPTH
//   fifo_idle                        : empty and no push this cycle
//   pwrbus_ram_pd / ram_pwrbus_ram_pd: RAM power control, passed through
//
// Handshake: a transfer happens on a rising clock edge when valid and ready
// are both high. Valid does not depend on ready. Once rd_pvld is high, it
// stays high with stable rd_pd until the pop takes place.
// ---------------------------------------------------------------------------
module nv_fifo_ctrl_rwsp_64x16 #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 16
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   fifo_count,
  output logic          fifo_idle,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   ram_pwrbus_ram_pd
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_used_cnt;  // written, not yet captured into the RAM output register
  logic [AW:0]   r_pend_cnt;  // written, read address not yet issued
  logic          r_s1_vld;    // RAM read-address register holds an issued entry
  logic          r_s2_vld;    // RAM output register holds data

  logic          w_push;
  logic          w_pop;
  logic          w_ore;
  logic          w_re;
  logic [AW:0]   w_count;

  // The occupancy includes the entry parked in the RAM output register.
  // Full is judged on this total, so that RAM plus output register never
  // hold more than DEPTH entries and fifo_count stays within 0..DEPTH.
  assign w_count = r_used_cnt + {{AW{1'b0}}, r_s2_vld};
  assign wr_prdy = (w_count != (AW+1)'(DEPTH));
  assign w_push  = wr_pvld & wr_prdy;

  // Stage S1 moves into S2 when S2 is empty or is being popped. A new
  // address issues when S1 is empty or is moving on in this cycle.
  assign w_ore   = r_s1_vld & (~r_s2_vld | rd_prdy);
  assign w_re    = (r_pend_cnt != '0) & (~r_s1_vld | w_ore);
  assign w_pop   = r_s2_vld & rd_prdy;

  assign rd_pvld    = r_s2_vld;
  assign rd_pd      = ram_dout;
  assign ram_we     = w_push;
  assign ram_wa     = r_wr_ptr;
  assign ram_di     = wr_pd;
  assign ram_re     = w_re;
  assign ram_ra     = r_rd_ptr;
  assign ram_ore    = w_ore;
  assign fifo_count = w_count;
  assign fifo_idle  = (w_count == '0) & ~w_push;

  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_used_cnt <= '0;
      r_pend_cnt <= '0;
      r_s1_vld   <= 1'b0;
      r_s2_vld   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_re)   r_rd_ptr <= r_rd_ptr + AW'(1);

      r_pend_cnt <= r_pend_cnt + (AW+1)'(w_push) - (AW+1)'(w_re);
      r_used_cnt <= r_used_cnt + (AW+1)'(w_push) - (AW+1)'(w_ore);

      if (w_re)       r_s1_vld <= 1'b1;
      else if (w_ore) r_s1_vld <= 1'b0;

      if (w_ore)      r_s2_vld <= 1'b1;
      else if (w_pop) r_s2_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nv_fifo_ctrl_rwsp_64x16.sv
// ---------------------------------------------------------------------------
// tb_nv_fifo_ctrl_rwsp_64x16
//   Self-checking bench for nv_fifo_ctrl_rwsp_64x16. It includes a
//   behavioural model of the 64x16 RAM (registered address, output register)
//   and a reference queue holding the words that are expected to pop next.
// ---------------------------------------------------------------------------
module tb_nv_fifo_ctrl_rwsp_64x16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_pvld, wr_prdy, rd_pvld, rd_prdy;
  logic [15:0] wr_pd, rd_pd, ram_di, ram_dout;
  logic        ram_we, ram_re, ram_ore, fifo_idle;
  logic [5:0]  ram_wa, ram_ra;
  logic [6:0]  fifo_count;
  logic [31:0] pwrbus_ram_pd, ram_pwrbus_ram_pd;

  nv_fifo_ctrl_rwsp_64x16 dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rst_n),
    .wr_pvld          (wr_pvld),
    .wr_prdy          (wr_prdy),
    .wr_pd            (wr_pd),
    .rd_pvld          (rd_pvld),
    .rd_prdy          (rd_prdy),
    .rd_pd            (rd_pd),
    .ram_we           (ram_we),
    .ram_wa           (ram_wa),
    .ram_di           (ram_di),
    .ram_re           (ram_re),
    .ram_ra           (ram_ra),
    .ram_ore          (ram_ore),
    .ram_dout         (ram_dout),
    .fifo_count       (fifo_count),
    .fifo_idle        (fifo_idle),
    .pwrbus_ram_pd    (pwrbus_ram_pd),
    .ram_pwrbus_ram_pd(ram_pwrbus_ram_pd)
  );

  // ---------------- RAM model ----------------
  logic [15:0] mem [64];
  logic [5:0]  m_ra;
  logic [15:0] m_dout;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  m_ra        <= ram_ra;
    if (ram_ore) m_dout      <= mem[m_ra];
  end
  assign ram_dout = m_dout;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_total = 0;

  task automatic model_push(input logic [15:0] d);
    exp_q.push_back(d);
    wr_total++;
  endtask

  // ---------------- driver ----------------
  // Drives the inputs just after a rising edge. It returns at the following
  // falling edge, when the outputs for this cycle are stable and can be sampled.
  task automatic step(input logic wv, input logic [15:0] wd, input logic rr);
    @(posedge clk);
    #1;
    wr_pvld = wv;
    wr_pd   = wd;
    rd_prdy = rr;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    n_checks += 7;
    if (rd_pvld !== 1'b0)       begin n_fail++; $display("FAIL reset_rd_pvld got %b want 0", rd_pvld); end
    if (wr_prdy !== 1'b1)       begin n_fail++; $display("FAIL reset_wr_prdy got %b want 1", wr_prdy); end
    if (fifo_count !== 7'd0)    begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    if (fifo_idle !== 1'b1)     begin n_fail++; $display("FAIL reset_idle got %b want 1", fifo_idle); end
    if (ram_we !== 1'b0)        begin n_fail++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
    if (ram_re !== 1'b0)        begin n_fail++; $display("FAIL reset_ram_re got %b want 0", ram_re); end
    if (ram_ore !== 1'b0)       begin n_fail++; $display("FAIL reset_ram_ore got %b want 0", ram_ore); end
  endtask

  task automatic test_latency;
    // cycle 0: push
    step(1'b1, 16'hA5A5, 1'b1);
    n_checks += 2;
    if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL lat_push_rdy got %b want 1", wr_prdy); end
    if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL lat_c0_pvld got %b want 0", rd_pvld); end
    wr_total++;
    // cycle 1: address issue
    step(1'b0, 16'h0, 1'b1);
    n_checks += 2;
    if (ram_re !== 1'b1)  begin n_fail++; $display("FAIL lat_c1_re got %b want 1", ram_re); end
    if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL lat_c1_pvld got %b want 0", rd_pvld); end
    // cycle 2: output register load
    step(1'b0, 16'h0, 1'b1);
    n_checks += 2;
    if (ram_ore !== 1'b1) begin n_fail++; $display("FAIL lat_c2_ore got %b want 1", ram_ore); end
    if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL lat_c2_pvld got %b want 0", rd_pvld); end
    // cycle 3: data valid
    step(1'b0, 16'h0, 1'b1);
    n_checks += 2;
    if (rd_pvld !== 1'b1)    begin n_fail++; $display("FAIL lat_c3_pvld got %b want 1", rd_pvld); end
    if (rd_pd !== 16'hA5A5)  begin n_fail++; $display("FAIL lat_c3_data got %h want a5a5", rd_pd); end
    // cycle 4: empty again
    step(1'b0, 16'h0, 1'b1);
    n_checks += 3;
    if (rd_pvld !== 1'b0)    begin n_fail++; $display("FAIL lat_c4_pvld got %b want 0", rd_pvld); end
    if (fifo_count !== 7'd0) begin n_fail++; $display("FAIL lat_c4_count got %0d want 0", fifo_count); end
    if (fifo_idle !== 1'b1)  begin n_fail++; $display("FAIL lat_c4_idle got %b want 1", fifo_idle); end
  endtask

  task automatic test_fill_drain;
    int pops = 0;
    logic [15:0] e;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 16'(i), 1'b0);
      n_checks++;
      if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL fill_rdy_%0d got %b want 1", i, wr_prdy); end
      if (wr_prdy) model_push(16'(i));
    end
    // Full: a push attempt must be refused.
    step(1'b1, 16'hDEAD, 1'b0);
    n_checks += 2;
    if (wr_prdy !== 1'b0)     begin n_fail++; $display("FAIL full_rdy got %b want 0", wr_prdy); end
    if (fifo_count !== 7'd64) begin n_fail++; $display("FAIL full_count got %0d want 64", fifo_count); end
    if (wr_prdy) model_push(16'hDEAD);
    // First pop: no same-cycle slot release.
    step(1'b0, 16'h0, 1'b1);
    n_checks += 2;
    if (rd_pvld !== 1'b1) begin n_fail++; $display("FAIL drain_first_pvld got %b want 1", rd_pvld); end
    if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL drain_first_rdy got %b want 0", wr_prdy); end
    if (rd_pvld) begin
      e = exp_q.pop_front();
      pops++;
      n_checks++;
      if (rd_pd !== e) begin n_fail++; $display("FAIL drain_data got %h want %h", rd_pd, e); end
    end
    step(1'b0, 16'h0, 1'b1);
    n_checks++;
    if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL drain_second_rdy got %b want 1", wr_prdy); end
    for (int c = 0; c < 200 && (exp_q.size() > 0 || rd_pvld); c++) begin
      if (c > 0) step(1'b0, 16'h0, 1'b1);
      if (rd_pvld) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL drain_extra got %h want none", rd_pd); end
        else begin
          e = exp_q.pop_front();
          pops++;
          if (rd_pd !== e) begin n_fail++; $display("FAIL drain_data got %h want %h", rd_pd, e); end
        end
      end
    end
    n_checks++;
    if (pops != 64) begin n_fail++; $display("FAIL drain_pop_count got %0d want 64", pops); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d, e;
    for (int c = 0; c < 200; c++) begin
      d = 16'($urandom);
      step(1'b1, d, 1'b1);
      n_checks++;
      if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy c%0d got %b want 1", c, wr_prdy); end
      if (c >= 3) begin
        n_checks += 2;
        if (rd_pvld !== 1'b1)    begin n_fail++; $display("FAIL b2b_pvld c%0d got %b want 1", c, rd_pvld); end
        if (fifo_count !== 7'd3) begin n_fail++; $display("FAIL b2b_count c%0d got %0d want 3", c, fifo_count); end
      end
      if (rd_pvld && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rd_pd !== e) begin n_fail++; $display("FAIL b2b_data c%0d got %h want %h", c, rd_pd, e); end
      end
      if (wr_prdy) model_push(d);
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step(1'b0, 16'h0, 1'b1);
      if (rd_pvld) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rd_pd !== e) begin n_fail++; $display("FAIL b2b_tail got %h want %h", rd_pd, e); end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_random;
    logic        wv, rr, hold, exp_rdy;
    logic [15:0] d, e, hold_pd;
    hold = 1'b0;
    hold_pd = '0;
    for (int c = 0; c < 10000; c++) begin
      wv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      d  = 16'($urandom);
      step(wv, d, rr);
      exp_rdy = (exp_q.size() < 64);
      n_checks += 3;
      if (wr_prdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_rdy c%0d got %b want %b", c, wr_prdy, exp_rdy); end
      if (fifo_count !== 7'(exp_q.size())) begin
        n_fail++; $display("FAIL rnd_count c%0d got %0d want %0d", c, fifo_count, exp_q.size());
      end
      if (fifo_idle !== ((exp_q.size() == 0) && !(wv && exp_rdy))) begin
        n_fail++; $display("FAIL rnd_idle c%0d got %b", c, fifo_idle);
      end
      if (hold) begin
        n_checks++;
        if (rd_pvld !== 1'b1 || rd_pd !== hold_pd) begin
          n_fail++; $display("FAIL rnd_stable c%0d got %b/%h want 1/%h", c, rd_pvld, rd_pd, hold_pd);
        end
      end
      if (rd_pvld && rr) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_extra c%0d got %h want none", c, rd_pd); end
        else begin
          e = exp_q.pop_front();
          if (rd_pd !== e) begin n_fail++; $display("FAIL rnd_data c%0d got %h want %h", c, rd_pd, e); end
        end
      end
      hold    = rd_pvld & ~rr;
      hold_pd = rd_pd;
      if (wv && wr_prdy) model_push(d);
    end
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      step(1'b0, 16'h0, 1'b1);
      if (rd_pvld) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rd_pd !== e) begin n_fail++; $display("FAIL rnd_tail got %h want %h", rd_pd, e); end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_full_wrap;
    logic [15:0] d, e, last;
    int align;
    // Align the write pointer to 0 so that the refill write lands on the wrap address.
    align = (64 - (wr_total % 64)) % 64;
    for (int i = 0; i < align; i++) begin
      step(1'b1, 16'h0, 1'b1);
      if (wr_prdy) wr_total++;
    end
    for (int c = 0; c < 20; c++) step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      d = 16'($urandom);
      step(1'b1, d, 1'b0);
      if (wr_prdy) model_push(d);
    end
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    n_checks += 2;
    if (fifo_count !== 7'd64) begin n_fail++; $display("FAIL wrap_full_count got %0d want 64", fifo_count); end
    if (wr_prdy !== 1'b0)     begin n_fail++; $display("FAIL wrap_full_rdy got %b want 0", wr_prdy); end
    // Pop and push together: the pop goes through, the push is held back.
    step(1'b1, 16'hBEEF, 1'b1);
    n_checks += 2;
    if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL wrap_pop_rdy got %b want 0", wr_prdy); end
    if (rd_pvld !== 1'b1) begin n_fail++; $display("FAIL wrap_pop_pvld got %b want 1", rd_pvld); end
    if (rd_pvld) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rd_pd !== e) begin n_fail++; $display("FAIL wrap_pop_data got %h want %h", rd_pd, e); end
    end
    step(1'b1, 16'hBEEF, 1'b0);
    n_checks++;
    if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL wrap_push_rdy got %b want 1", wr_prdy); end
    if (wr_prdy) model_push(16'hBEEF);
    last = 16'h0;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      step(1'b0, 16'h0, 1'b1);
      if (rd_pvld) begin
        e = exp_q.pop_front();
        last = rd_pd;
        n_checks++;
        if (rd_pd !== e) begin n_fail++; $display("FAIL wrap_drain got %h want %h", rd_pd, e); end
      end
    end
    n_checks += 2;
    if (exp_q.size() != 0)  begin n_fail++; $display("FAIL wrap_left got %0d want 0", exp_q.size()); end
    if (last !== 16'hBEEF)  begin n_fail++; $display("FAIL wrap_last got %h want beef", last); end
  endtask

  task automatic test_reset_mid;
    logic got;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(16'h100 + i), 1'b0);
      if (wr_prdy) model_push(16'(16'h100 + i));
    end
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (rd_pvld !== 1'b0)    begin n_fail++; $display("FAIL rstmid_pvld got %b want 0", rd_pvld); end
    if (fifo_count !== 7'd0) begin n_fail++; $display("FAIL rstmid_count got %0d want 0", fifo_count); end
    if (wr_prdy !== 1'b1)    begin n_fail++; $display("FAIL rstmid_rdy got %b want 1", wr_prdy); end
    exp_q.delete();
    wr_total = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h1234, 1'b1);
    if (wr_prdy) model_push(16'h1234);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step(1'b0, 16'h0, 1'b1);
      if (rd_pvld) begin
        got = 1'b1;
        n_checks++;
        if (rd_pd !== 16'h1234) begin n_fail++; $display("FAIL rstmid_first got %h want 1234", rd_pd); end
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL rstmid_timeout got none want 1234"); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    wr_pvld       = 1'b0;
    wr_pd         = '0;
    rd_prdy       = 1'b0;
    pwrbus_ram_pd = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_latency();
    test_fill_drain();
    test_back_to_back();
    test_random();
    test_full_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
